// File: rtl/if_filt_rd_addr_gen.sv
// rtl/if_filt_rd_addr_gen.sv - read-address generator for the IF and filter scratchpads of one PE
//
// Purpose: walks the filter taps of one output window, strides the IF window along
// a row and reports window, stride and row completion back to the PE controller.
// Optional build macro: RD_ADDR_REG_EN adds a register stage on rd_en, if_raddr,
// filt_raddr and psum_done. Without it these outputs are combinational.
//
// Ports:
//   i_clk, i_rst (async, active-low), i_sync_clr (sync clear of all state)
//   i_rd_gen_en      level enable from the controller
//   i_clear_regs     abort the current window and restart its taps
//   i_reset_filter   clear the tap pointer only
//   i_stride_en      gates o_stride_pos_ld
//   i_filt_len       taps per window (0 = no-op)
//   i_stride         window step
//   i_row_len        IF words in the current row
//   i_last_row       current row is the final row
//   i_if_cnt         IF words written so far for this row
//   i_filt_ready     filter scratchpad is loaded
//   i_hold           downstream back-pressure
//   o_rd_en          tap read strobe
//   o_if_raddr       IF scratchpad read address (base + tap, circular)
//   o_filt_raddr     filter scratchpad read address (tap)
//   o_psum_done      last tap of the window issued
//   o_stride_pos_ld  window advanced
//   o_stride_count_flag  no further full window fits in the row
//   o_full_done      final window of the final row complete
module if_filt_rd_addr_gen #(
  parameter int IF_ADDR_LEN   = 4,
  parameter int FILT_ADDR_LEN = 4,
  parameter int ROW_W         = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_sync_clr,
  input  logic                     i_rd_gen_en,
  input  logic                     i_clear_regs,
  input  logic                     i_reset_filter,
  input  logic                     i_stride_en,
  input  logic [FILT_ADDR_LEN-1:0] i_filt_len,
  input  logic [ROW_W-1:0]         i_stride,
  input  logic [ROW_W-1:0]         i_row_len,
  input  logic                     i_last_row,
  input  logic [ROW_W-1:0]         i_if_cnt,
  input  logic                     i_filt_ready,
  input  logic                     i_hold,
  output logic                     o_rd_en,
  output logic [IF_ADDR_LEN-1:0]   o_if_raddr,
  output logic [FILT_ADDR_LEN-1:0] o_filt_raddr,
  output logic                     o_psum_done,
  output logic                     o_stride_pos_ld,
  output logic                     o_stride_count_flag,
  output logic                     o_full_done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_ADV} state_t;

  state_t                   r_state;
  logic [ROW_W-1:0]         r_pos;
  logic [IF_ADDR_LEN-1:0]   r_base;
  logic [FILT_ADDR_LEN-1:0] r_tap;

  logic [ROW_W:0]           w_word_idx;
  logic                     w_avail;
  logic                     w_issue;
  logic                     w_last;
  logic                     w_adv;
  logic [ROW_W+1:0]         w_next_end;
  logic                     w_row_end;
  logic [IF_ADDR_LEN-1:0]   w_if_addr;
  logic [FILT_ADDR_LEN-1:0] w_filt_addr;

  // Word index of the current tap; one extra bit so pos+tap cannot wrap.
  assign w_word_idx = {1'b0, r_pos} + {{(ROW_W+1-FILT_ADDR_LEN){1'b0}}, r_tap};
  assign w_avail    = w_word_idx < {1'b0, i_if_cnt};

  // hold, clear_regs and reset_filter all win over an issue in the same cycle.
  assign w_issue = (r_state == S_RUN) && i_rd_gen_en && !i_sync_clr && i_filt_ready &&
                   !i_hold && !i_clear_regs && !i_reset_filter && w_avail;
  assign w_last  = w_issue && (r_tap == i_filt_len - FILT_ADDR_LEN'(1));
  assign w_adv   = (r_state == S_ADV) && i_rd_gen_en && !i_sync_clr;

  // The next window starts at pos+stride and needs filt_len words inside the row.
  assign w_next_end = {2'b00, r_pos} + {2'b00, i_stride} +
                      {{(ROW_W+2-FILT_ADDR_LEN){1'b0}}, i_filt_len};
  assign w_row_end  = w_adv && (w_next_end > {2'b00, i_row_len});

  assign w_if_addr   = i_sync_clr ? '0 : r_base + IF_ADDR_LEN'(r_tap);
  assign w_filt_addr = i_sync_clr ? '0 : r_tap;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
      r_pos   <= '0;
      r_base  <= '0;
      r_tap   <= '0;
    end else if (i_sync_clr) begin
      r_state <= S_IDLE;
      r_pos   <= '0;
      r_base  <= '0;
      r_tap   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_reset_filter) r_tap <= '0;
          if (i_rd_gen_en && (i_filt_len != '0)) r_state <= S_RUN;
        end
        S_RUN: begin
          if (!i_rd_gen_en) begin
            r_state <= S_IDLE;
          end else if (i_clear_regs || i_reset_filter) begin
            r_tap <= '0;
          end else if (w_last) begin
            r_tap   <= '0;
            r_state <= S_ADV;
          end else if (w_issue) begin
            r_tap <= r_tap + FILT_ADDR_LEN'(1);
          end
        end
        S_ADV: begin
          if (!i_rd_gen_en) begin
            r_state <= S_IDLE;
          end else begin
            if (i_reset_filter) r_tap <= '0;
            if (w_row_end) begin
              r_pos   <= '0;
              r_base  <= '0;
              r_state <= S_IDLE;
            end else begin
              r_pos   <= r_pos + i_stride;
              r_base  <= r_base + IF_ADDR_LEN'(i_stride);
              r_state <= S_RUN;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_stride_pos_ld     = w_adv && i_stride_en;
  assign o_stride_count_flag = w_row_end;
  assign o_full_done         = w_row_end && i_last_row;

`ifdef RD_ADDR_REG_EN
  logic                     r_rd_en;
  logic [IF_ADDR_LEN-1:0]   r_if_raddr;
  logic [FILT_ADDR_LEN-1:0] r_filt_raddr;
  logic                     r_psum_done;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_rd_en      <= 1'b0;
      r_if_raddr   <= '0;
      r_filt_raddr <= '0;
      r_psum_done  <= 1'b0;
    end else if (i_sync_clr) begin
      r_rd_en      <= 1'b0;
      r_if_raddr   <= '0;
      r_filt_raddr <= '0;
      r_psum_done  <= 1'b0;
    end else begin
      r_rd_en      <= w_issue;
      r_if_raddr   <= w_if_addr;
      r_filt_raddr <= w_filt_addr;
      r_psum_done  <= w_last;
    end
  end

  assign o_rd_en      = r_rd_en;
  assign o_if_raddr   = r_if_raddr;
  assign o_filt_raddr = r_filt_raddr;
  assign o_psum_done  = r_psum_done;
`else
  assign o_rd_en      = w_issue;
  assign o_if_raddr   = w_if_addr;
  assign o_filt_raddr = w_filt_addr;
  assign o_psum_done  = w_last;
`endif

endmodule
